// File: rtl/mor1kx_multiplier_marocchino.sv
// Three-stage 32x32 multiplier (capture, 16x16 partials, sum) with a WB result register.
// Optional SR[OV]/SR[CY] flag generation is enabled by defining MAROCCHINO_MUL_OVERFLOW_EN.
module mor1kx_multiplier_marocchino #(
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pipeline_flush_i,
  input  logic                            padv_exec_i,
  input  logic                            exec_op_mul_i,
  input  logic                            exec_op_mul_signed_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] exec_a_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] exec_b_i,
  input  logic                            padv_wb_i,
  output logic                            mul_busy_o,
  output logic                            mul_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wb_mul_result_o,
  output logic                            wb_mul_rdy_o,
  output logic                            exec_overflow_set_o,
  output logic                            exec_overflow_clear_o,
  output logic                            exec_carry_set_o,
  output logic                            exec_carry_clear_o
);

  logic        s1_valid;
  logic        s2_valid;
  logic        done;
  logic        issue;
  logic        consume;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] lolo_r;
  logic [31:0] res_r;

  assign mul_busy_o  = s1_valid | s2_valid | done;
  assign mul_valid_o = done;
  assign issue       = padv_exec_i & exec_op_mul_i & ~mul_busy_o & ~pipeline_flush_i;
  // done implies busy, so a consume and an issue can never coincide
  assign consume     = padv_wb_i & done & ~pipeline_flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      done     <= 1'b0;
    end else if (pipeline_flush_i) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      s1_valid <= issue;
      s2_valid <= s1_valid;
      if (s2_valid)
        done <= 1'b1;
      else if (consume)
        done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
    end else if (issue) begin
      a_r <= exec_a_i;
      b_r <= exec_b_i;
    end
  end

`ifdef MAROCCHINO_MUL_OVERFLOW_EN
  logic        sgn_r;
  logic        sgn2_r;
  logic [32:0] cross_r;
  logic [31:0] hihi_r;
  logic [31:0] corr_r;
  logic [63:0] prod;
  logic        ov_set_r;
  logic        ov_clr_r;
  logic        cy_set_r;
  logic        cy_clr_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sgn_r <= 1'b0;
    else if (issue)
      sgn_r <= exec_op_mul_signed_i;
  end

  // Signed product = unsigned product minus each operand shifted by 32 when the other is negative
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lolo_r  <= '0;
      cross_r <= '0;
      hihi_r  <= '0;
      corr_r  <= '0;
      sgn2_r  <= 1'b0;
    end else if (s1_valid) begin
      lolo_r  <= a_r[15:0] * b_r[15:0];
      cross_r <= {1'b0, a_r[31:16] * b_r[15:0]} + {1'b0, a_r[15:0] * b_r[31:16]};
      hihi_r  <= a_r[31:16] * b_r[31:16];
      corr_r  <= ((sgn_r & a_r[31]) ? b_r : 32'd0) + ((sgn_r & b_r[31]) ? a_r : 32'd0);
      sgn2_r  <= sgn_r;
    end
  end

  assign prod = {hihi_r, 32'd0} + {15'd0, cross_r, 16'd0} + {32'd0, lolo_r} - {corr_r, 32'd0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r <= '0;
    end else if (s2_valid) begin
      res_r <= prod[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_set_r <= 1'b0;
      ov_clr_r <= 1'b0;
      cy_set_r <= 1'b0;
      cy_clr_r <= 1'b0;
    end else if (pipeline_flush_i || consume) begin
      ov_set_r <= 1'b0;
      ov_clr_r <= 1'b0;
      cy_set_r <= 1'b0;
      cy_clr_r <= 1'b0;
    end else if (s2_valid) begin
      if (sgn2_r) begin
        ov_set_r <= ~((&prod[63:31]) | ~(|prod[63:31]));
        ov_clr_r <= (&prod[63:31]) | ~(|prod[63:31]);
        cy_set_r <= 1'b0;
        cy_clr_r <= 1'b0;
      end else begin
        ov_set_r <= 1'b0;
        ov_clr_r <= 1'b0;
        cy_set_r <= |prod[63:32];
        cy_clr_r <= ~(|prod[63:32]);
      end
    end
  end

  assign exec_overflow_set_o   = ov_set_r;
  assign exec_overflow_clear_o = ov_clr_r;
  assign exec_carry_set_o      = cy_set_r;
  assign exec_carry_clear_o    = cy_clr_r;
`else
  logic [15:0] cross_r;
  logic        unused_sgn;

  // Low 32 bits of the product do not depend on operand signedness
  assign unused_sgn = exec_op_mul_signed_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lolo_r  <= '0;
      cross_r <= '0;
    end else if (s1_valid) begin
      lolo_r  <= a_r[15:0] * b_r[15:0];
      cross_r <= a_r[31:16] * b_r[15:0] + a_r[15:0] * b_r[31:16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      res_r <= '0;
    else if (s2_valid)
      res_r <= lolo_r + {cross_r, 16'd0};
  end

  assign exec_overflow_set_o   = 1'b0;
  assign exec_overflow_clear_o = 1'b0;
  assign exec_carry_set_o      = 1'b0;
  assign exec_carry_clear_o    = 1'b0;
`endif

  // Result register is deliberately left intact on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_mul_result_o <= '0;
      wb_mul_rdy_o    <= 1'b0;
    end else if (pipeline_flush_i) begin
      wb_mul_rdy_o    <= 1'b0;
    end else if (padv_wb_i) begin
      if (done) begin
        wb_mul_result_o <= res_r;
        wb_mul_rdy_o    <= 1'b1;
      end else begin
        wb_mul_rdy_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_multiplier_marocchino.sv
// Directed plus random bench for the MAROCCHINO multiplier against a plain-arithmetic model.
module tb_mor1kx_multiplier_marocchino;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipeline_flush_i = 1'b0;
  logic        padv_exec_i = 1'b0;
  logic        exec_op_mul_i = 1'b0;
  logic        exec_op_mul_signed_i = 1'b0;
  logic [31:0] exec_a_i = '0;
  logic [31:0] exec_b_i = '0;
  logic        padv_wb_i = 1'b0;
  logic        mul_busy_o;
  logic        mul_valid_o;
  logic [31:0] wb_mul_result_o;
  logic        wb_mul_rdy_o;
  logic        exec_overflow_set_o;
  logic        exec_overflow_clear_o;
  logic        exec_carry_set_o;
  logic        exec_carry_clear_o;

  int total = 0;
  int bad   = 0;

  mor1kx_multiplier_marocchino #(.OPTION_OPERAND_WIDTH(32)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .pipeline_flush_i      (pipeline_flush_i),
    .padv_exec_i           (padv_exec_i),
    .exec_op_mul_i         (exec_op_mul_i),
    .exec_op_mul_signed_i  (exec_op_mul_signed_i),
    .exec_a_i              (exec_a_i),
    .exec_b_i              (exec_b_i),
    .padv_wb_i             (padv_wb_i),
    .mul_busy_o            (mul_busy_o),
    .mul_valid_o           (mul_valid_o),
    .wb_mul_result_o       (wb_mul_result_o),
    .wb_mul_rdy_o          (wb_mul_rdy_o),
    .exec_overflow_set_o   (exec_overflow_set_o),
    .exec_overflow_clear_o (exec_overflow_clear_o),
    .exec_carry_set_o      (exec_carry_set_o),
    .exec_carry_clear_o    (exec_carry_clear_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {28'd0, exec_overflow_set_o, exec_overflow_clear_o, exec_carry_set_o, exec_carry_clear_o};
  endfunction

  // Model: low word of the true product, flags from the range of the full-width product
  function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b);
    longint unsigned pu;
    pu = longint'(a) * longint'(b);
    return pu[31:0];
  endfunction

  function automatic logic [31:0] model_flags(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] f;
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    f  = 32'd0;
    sa = $signed(a);
    sb = $signed(b);
    ps = sa * sb;
    ua = longint'(a);
    ub = longint'(b);
    pu = ua * ub;
`ifdef MAROCCHINO_MUL_OVERFLOW_EN
    if (sgn) begin
      if (ps < -64'sd2147483648 || ps > 64'sd2147483647) f = 32'd8;
      else f = 32'd4;
    end else begin
      if (pu > 64'd4294967295) f = 32'd2;
      else f = 32'd1;
    end
`endif
    return f;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    padv_exec_i = 1'b1;
    exec_op_mul_i = 1'b1;
    exec_op_mul_signed_i = sgn;
    exec_a_i = a;
    exec_b_i = b;
    tick();
    padv_exec_i = 1'b0;
    exec_op_mul_i = 1'b0;
  endtask

  task automatic wb_step();
    padv_wb_i = 1'b1;
    tick();
    padv_wb_i = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input string tag);
    logic [31:0] er;
    logic [31:0] ef;
    er = model_res(a, b);
    ef = model_flags(a, b, sgn);
    chk({tag, ".idle"}, {31'd0, mul_busy_o}, 32'd0);
    issue(a, b, sgn);
    chk({tag, ".busy"}, {31'd0, mul_busy_o}, 32'd1);
    chk({tag, ".v1"}, {31'd0, mul_valid_o}, 32'd0);
    tick();
    chk({tag, ".v2"}, {31'd0, mul_valid_o}, 32'd0);
    tick();
    chk({tag, ".v3"}, {31'd0, mul_valid_o}, 32'd1);
    chk({tag, ".flags"}, flags_now(), ef);
    wb_step();
    chk({tag, ".res"}, wb_mul_result_o, er);
    chk({tag, ".rdy"}, {31'd0, wb_mul_rdy_o}, 32'd1);
    chk({tag, ".busy_drop"}, {31'd0, mul_busy_o}, 32'd0);
    chk({tag, ".flags_clr"}, flags_now(), 32'd0);
    wb_step();
    chk({tag, ".rdy_next"}, {31'd0, wb_mul_rdy_o}, 32'd0);
    chk({tag, ".res_hold"}, wb_mul_result_o, er);
  endtask

  initial begin
    logic [31:0] first_exp;
    #12;
    chk("rst.busy", {31'd0, mul_busy_o}, 32'd0);
    chk("rst.valid", {31'd0, mul_valid_o}, 32'd0);
    chk("rst.rdy", {31'd0, wb_mul_rdy_o}, 32'd0);
    chk("rst.res", wb_mul_result_o, 32'd0);
    chk("rst.flags", flags_now(), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(32'h0000_0007, 32'h0000_0006, 1'b0, "mul7x6");
    run_op(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, "neg2x3");
    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, "carry");
    run_op(32'h4000_0000, 32'h0000_0004, 1'b1, "ovf");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "minx-1");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "maxu");

    // flush one cycle after issue; make rdy high first so its clearing is visible
    issue(32'd2, 32'd2, 1'b0);
    tick(); tick();
    wb_step();
    issue(32'd100, 32'd100, 1'b0);
    pipeline_flush_i = 1'b1;
    tick();
    pipeline_flush_i = 1'b0;
    chk("flush1.busy", {31'd0, mul_busy_o}, 32'd0);
    chk("flush1.rdy", {31'd0, wb_mul_rdy_o}, 32'd0);
    chk("flush1.res_kept", wb_mul_result_o, 32'd4);
    run_op(32'd3, 32'd5, 1'b0, "reissue");

    // flush while the result waits for writeback
    issue(32'd77, 32'd3, 1'b0);
    tick(); tick();
    pipeline_flush_i = 1'b1;
    tick();
    pipeline_flush_i = 1'b0;
    chk("flush3.valid", {31'd0, mul_valid_o}, 32'd0);
    wb_step();
    chk("flush3.rdy", {31'd0, wb_mul_rdy_o}, 32'd0);
    chk("flush3.res", wb_mul_result_o, 32'd15);

    // stall writeback; an issue while busy must be dropped
    first_exp = model_res(32'h1234_5678, 32'h9ABC_DEF0);
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        padv_exec_i = 1'b1; exec_op_mul_i = 1'b1;
        exec_a_i = 32'd9; exec_b_i = 32'd9;
      end
      tick();
      padv_exec_i = 1'b0; exec_op_mul_i = 1'b0;
      chk($sformatf("stall.busy%0d", i), {31'd0, mul_busy_o}, 32'd1);
    end
    wb_step();
    chk("stall.res", wb_mul_result_o, first_exp);
    for (int i = 0; i < 4; i++) tick();
    chk("stall.no_second", {31'd0, mul_busy_o | mul_valid_o}, 32'd0);

    // asynchronous reset while the op sits in stage 2
    issue(32'd5, 32'd7, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", {31'd0, mul_busy_o}, 32'd0);
    chk("arst.valid", {31'd0, mul_valid_o}, 32'd0);
    chk("arst.res", wb_mul_result_o, 32'd0);
    chk("arst.rdy", {31'd0, wb_mul_rdy_o}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    run_op(32'd11, 32'd13, 1'b0, "post_rst");

    for (int i = 0; i < 30; i++)
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
